count_pulse_debouncer: RTL

Upstream stage for the four-bit counter: conditions a raw, bouncing push-button into clean single-cycle increment pulses. It provides a two-flop synchronizer, a debounce FSM and an optional auto-repeat generator. Its pulse output drives the counter's count-enable, one increment per press or per repeat tick. Its rst also resets the counter.

---
 rtl/count_pulse_debouncer_pkg.sv | 33 +++
 rtl/count_pulse_debouncer_sync.sv | 24 ++
 rtl/count_pulse_debouncer.sv | 110 +++++++++++
 3 files changed

// File: rtl/count_pulse_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// elaboration-time parameter legality checks (also reused by the counter bench).
`ifndef COUNT_PULSE_DEBOUNCER_PKG_SV
`define COUNT_PULSE_DEBOUNCER_PKG_SV

package count_pulse_debouncer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_HELD    = 3'd2,
      ST_REPEAT  = 3'd3,
      ST_RELEASE = 3'd4
   } cpd_state_e;

   // Every terminal timer value must fit, so the timer can never wrap.
   function automatic bit cpd_params_ok(input int dbc, input int dly, input int rate,
                                        input int tw);
      int lim;
      if (tw < 1 || tw > 30) return 1'b0;
      lim = 1 << tw;
      return (dbc >= 1) && (dly >= 1) && (rate >= 1) &&
             (dbc < lim) && (dly < lim) && (rate < lim);
   endfunction

endpackage

`define CPD_CHECK_PARAMS(DB, DLY, RATE, TW) \
   if (!count_pulse_debouncer_pkg::cpd_params_ok(DB, DLY, RATE, TW)) begin : g_bad_params \
      $error("count_pulse_debouncer: illegal parameter set"); \
   end

`endif

// File: rtl/count_pulse_debouncer_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/count_pulse_debouncer.sv
// Push-button conditioner: synchronizer, debounce FSM and auto-repeat, producing
// single-cycle count-enable pulses for the four-bit counter.
module count_pulse_debouncer
   import count_pulse_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_RATE     = 16,
   parameter int TIMER_W         = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   input  logic repeat_en,
   output logic pulse,
   output logic btn_level,
   output logic repeating
);

   `CPD_CHECK_PARAMS(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE, TIMER_W)

   localparam logic [TIMER_W-1:0] DB_LAST   = TIMER_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DLY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
   localparam logic [TIMER_W-1:0] RATE_LAST = TIMER_W'(REPEAT_RATE - 1);

   logic               s;
   cpd_state_e         state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               pulse_q, pulse_d;
   logic               level_q, level_d;

   sync_2ff u_sync (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (btn_in),
      .q_o   (s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pulse_q <= pulse_d;
         level_q <= level_d;
      end
   end

   // A drop of s is always tested first so it beats any terminal-count event.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + TIMER_W'(1);
      unique case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (s) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (!s)                      state_d = ST_IDLE;
            else if (timer_q == DB_LAST) state_d = ST_HELD;
         end
         ST_HELD: begin
            if (!s) state_d = ST_RELEASE;
            else if (timer_q == DLY_LAST) begin
               if (repeat_en) state_d = ST_REPEAT;
               else           timer_d = timer_q;
            end
         end
         ST_REPEAT: begin
            if (!s) state_d = ST_RELEASE;
            else if (!repeat_en) begin
               state_d = ST_HELD;
               timer_d = DLY_LAST;
            end else if (timer_q == RATE_LAST) timer_d = '0;
         end
         ST_RELEASE: begin
            if (s)                       state_d = ST_HELD;
            else if (timer_q == DB_LAST) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // REPEAT->HELD keeps the saturated delay so re-enabling repeat fires at once.
      if (state_d != state_q && !(state_q == ST_REPEAT && state_d == ST_HELD))
         timer_d = '0;
   end

   always_comb begin
      pulse_d = 1'b0;
      level_d = level_q;
      unique case (state_q)
         ST_ARM: if (state_d == ST_HELD) begin
            pulse_d = 1'b1;
            level_d = 1'b1;
         end
         ST_HELD:    if (state_d == ST_REPEAT) pulse_d = 1'b1;
         ST_REPEAT:  if (state_d == ST_REPEAT && timer_q == RATE_LAST) pulse_d = 1'b1;
         ST_RELEASE: if (state_d == ST_IDLE) level_d = 1'b0;
         default: ;
      endcase
   end

   assign pulse     = pulse_q;
   assign btn_level = level_q;
   assign repeating = (state_q == ST_REPEAT);

endmodule
